mc_control_fsm: RTL and testbench

MC_CONTROL_FSM -- requirements
Module: mc_control_fsm

---
 rtl/mc_ctrl_pkg.sv | 70 +++++++
 rtl/mc_control_fsm_decode.sv | 60 ++++++
 rtl/mc_control_fsm.sv | 143 ++++++++++++++
 tb/tb_mc_control_fsm.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mc_ctrl_pkg.sv
// Shared definitions for the multi-cycle control FSM.
// Holds opcode/func constants, state and class enums, ctrl bit indices and mux encodings.
package mc_ctrl_pkg;

    localparam logic [3:0] OP_BNE = 4'd0;
    localparam logic [3:0] OP_BEQ = 4'd1;
    localparam logic [3:0] OP_BGZ = 4'd2;
    localparam logic [3:0] OP_BLZ = 4'd3;
    localparam logic [3:0] OP_ADI = 4'd4;
    localparam logic [3:0] OP_ORI = 4'd5;
    localparam logic [3:0] OP_LHI = 4'd6;
    localparam logic [3:0] OP_LWD = 4'd7;
    localparam logic [3:0] OP_SWD = 4'd8;
    localparam logic [3:0] OP_JMP = 4'd9;
    localparam logic [3:0] OP_JAL = 4'd10;
    localparam logic [3:0] OP_ALU = 4'd15;

    localparam logic [5:0] FN_JPR = 6'd25;
    localparam logic [5:0] FN_JRL = 6'd26;
    localparam logic [5:0] FN_WWD = 6'd28;
    localparam logic [5:0] FN_HLT = 6'd29;

    typedef enum logic [2:0] {
        S_IF   = 3'd0,
        S_ID   = 3'd1,
        S_EX   = 3'd2,
        S_MEM  = 3'd3,
        S_WB   = 3'd4,
        S_HALT = 3'd5
    } state_e;

    typedef enum logic [3:0] {
        CLS_NOP  = 4'd0,
        CLS_ALU  = 4'd1,
        CLS_IMM  = 4'd2,
        CLS_LWD  = 4'd3,
        CLS_SWD  = 4'd4,
        CLS_BR   = 4'd5,
        CLS_JUMP = 4'd6,
        CLS_WWD  = 4'd7,
        CLS_HLT  = 4'd8
    } cls_e;

    // ctrl bundle layout; multi-bit fields are 2 bits wide starting at *_LO
    localparam int unsigned CTRL_PC_WRITE  = 0;
    localparam int unsigned CTRL_IR_WRITE  = 1;
    localparam int unsigned CTRL_MEM_READ  = 2;
    localparam int unsigned CTRL_MEM_WRITE = 3;
    localparam int unsigned CTRL_IORD      = 4;
    localparam int unsigned CTRL_REG_WRITE = 5;
    localparam int unsigned CTRL_OUT_EN    = 6;
    localparam int unsigned CTRL_PC_SRC_LO = 7;
    localparam int unsigned CTRL_WB_SRC_LO = 9;
    localparam int unsigned CTRL_DEST_LO   = 11;
    localparam int unsigned CTRL_NUM       = 13;

    localparam logic [1:0] PC_SRC_PC1    = 2'd0;
    localparam logic [1:0] PC_SRC_TARGET = 2'd1;
    localparam logic [1:0] PC_SRC_REG    = 2'd2;
    localparam logic [1:0] PC_SRC_BRANCH = 2'd3;

    localparam logic [1:0] WB_SRC_ALU = 2'd0;
    localparam logic [1:0] WB_SRC_MEM = 2'd1;
    localparam logic [1:0] WB_SRC_PC  = 2'd2;

    localparam logic [1:0] DEST_RD = 2'd0;
    localparam logic [1:0] DEST_RT = 2'd1;
    localparam logic [1:0] DEST_R2 = 2'd2;

endpackage

// File: rtl/mc_control_fsm_decode.sv
// Combinational decode of the IR into an instruction class plus branch outcome.
// Anything not recognised decodes to CLS_NOP.
module mc_ctrl_decode
    import mc_ctrl_pkg::*;
#(
    parameter int WORD_SIZE = 16
) (
    input  logic [WORD_SIZE-1:0] inst_i,
    input  logic [WORD_SIZE-1:0] bcond_i,
    output logic [3:0]           cls_o,
    output logic                 jmp_reg_o,
    output logic                 link_o,
    output logic                 br_taken_o
);

    logic [3:0] opcode;
    logic [5:0] func;
    logic       bc_zero;
    logic       bc_neg;
    logic       unused_inst_bits;

    assign opcode           = inst_i[WORD_SIZE-1:WORD_SIZE-4];
    assign func             = inst_i[5:0];
    assign bc_zero          = (bcond_i == '0);
    assign bc_neg           = bcond_i[WORD_SIZE-1];
    assign unused_inst_bits = ^inst_i[WORD_SIZE-5:6];

    always_comb begin
        cls_o      = CLS_NOP;
        jmp_reg_o  = 1'b0;
        link_o     = 1'b0;
        br_taken_o = 1'b0;
        case (opcode)
            OP_ALU: begin
                if (func < 6'd8) begin
                    cls_o = CLS_ALU;
                end else begin
                    case (func)
                        FN_JPR: begin cls_o = CLS_JUMP; jmp_reg_o = 1'b1; end
                        FN_JRL: begin cls_o = CLS_JUMP; jmp_reg_o = 1'b1; link_o = 1'b1; end
                        FN_WWD: cls_o = CLS_WWD;
                        FN_HLT: cls_o = CLS_HLT;
                        default: cls_o = CLS_NOP;
                    endcase
                end
            end
            OP_ADI, OP_ORI, OP_LHI: cls_o = CLS_IMM;
            OP_LWD: cls_o = CLS_LWD;
            OP_SWD: cls_o = CLS_SWD;
            OP_BNE: begin cls_o = CLS_BR; br_taken_o = !bc_zero; end
            OP_BEQ: begin cls_o = CLS_BR; br_taken_o = bc_zero; end
            OP_BGZ: begin cls_o = CLS_BR; br_taken_o = !bc_neg && !bc_zero; end
            OP_BLZ: begin cls_o = CLS_BR; br_taken_o = bc_neg; end
            OP_JMP: cls_o = CLS_JUMP;
            OP_JAL: begin cls_o = CLS_JUMP; link_o = 1'b1; end
            default: cls_o = CLS_NOP;
        endcase
    end

endmodule

// File: rtl/mc_control_fsm.sv
// Multi-cycle CPU control FSM: sequencing, control bundle and retired-instruction counter.
// Define MEM_HANDSHAKE_EN to make IF and MEM wait for mem_ready.
module mc_control_fsm
    import mc_ctrl_pkg::*;
#(
    parameter int WORD_SIZE = 16,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [WORD_SIZE-1:0] inst,
    input  logic [WORD_SIZE-1:0] bcond,
    input  logic                 mem_ready,
    output logic [CTRL_NUM-1:0]  ctrl,
    output logic [2:0]           state_o,
    output logic [CNT_WIDTH-1:0] num_inst,
    output logic                 is_halted
);

    state_e               state_q, state_d;
    logic [CNT_WIDTH-1:0] cnt_q;
    logic                 halted_q;
    logic [CTRL_NUM-1:0]  ctrl_c;
    logic [3:0]           cls_raw;
    cls_e                 cls;
    logic                 jmp_reg, link, br_taken;
    logic                 mem_done;
    logic                 retire;

`ifdef MEM_HANDSHAKE_EN
    assign mem_done = mem_ready;
`else
    logic unused_mem_ready;
    assign unused_mem_ready = mem_ready;
    assign mem_done         = 1'b1;
`endif

    mc_ctrl_decode #(
        .WORD_SIZE(WORD_SIZE)
    ) u_decode (
        .inst_i    (inst),
        .bcond_i   (bcond),
        .cls_o     (cls_raw),
        .jmp_reg_o (jmp_reg),
        .link_o    (link),
        .br_taken_o(br_taken)
    );

    assign cls = cls_e'(cls_raw);

    always_ff @(posedge clk) begin
        if (!reset_n) state_q <= S_IF;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IF: if (mem_done) state_d = S_ID;
            S_ID: begin
                case (cls)
                    CLS_ALU, CLS_IMM, CLS_LWD, CLS_SWD, CLS_BR: state_d = S_EX;
                    CLS_HLT: state_d = S_HALT;
                    default: state_d = S_IF;
                endcase
            end
            S_EX: begin
                case (cls)
                    CLS_LWD, CLS_SWD: state_d = S_MEM;
                    CLS_BR:           state_d = S_IF;
                    default:          state_d = S_WB;
                endcase
            end
            S_MEM: if (mem_done) state_d = (cls == CLS_LWD) ? S_WB : S_IF;
            S_WB:   state_d = S_IF;
            S_HALT: state_d = S_HALT;
            default: state_d = S_IF;
        endcase
    end

    // An instruction retires when any non-IF state hands over to IF or HALT
    assign retire = (state_q != S_IF) && (state_q != S_HALT) &&
                    ((state_d == S_IF) || (state_d == S_HALT));

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cnt_q    <= '0;
            halted_q <= 1'b0;
        end else begin
            if (retire)            cnt_q    <= cnt_q + 1'b1;
            if (state_d == S_HALT) halted_q <= 1'b1;
        end
    end

    always_comb begin
        ctrl_c = '0;
        if (reset_n) begin
            case (state_q)
                S_IF: begin
                    ctrl_c[CTRL_MEM_READ]              = 1'b1;
                    ctrl_c[CTRL_IR_WRITE]              = mem_done;
                    ctrl_c[CTRL_PC_WRITE]              = mem_done;
                    ctrl_c[CTRL_PC_SRC_LO +: 2]        = PC_SRC_PC1;
                end
                S_ID: begin
                    if (cls == CLS_JUMP) begin
                        ctrl_c[CTRL_PC_WRITE]          = 1'b1;
                        ctrl_c[CTRL_PC_SRC_LO +: 2]    = jmp_reg ? PC_SRC_REG : PC_SRC_TARGET;
                        if (link) begin
                            ctrl_c[CTRL_REG_WRITE]     = 1'b1;
                            ctrl_c[CTRL_WB_SRC_LO +: 2] = WB_SRC_PC;
                            ctrl_c[CTRL_DEST_LO +: 2]  = DEST_R2;
                        end
                    end
                    ctrl_c[CTRL_OUT_EN]                = (cls == CLS_WWD);
                end
                S_EX: begin
                    if (cls == CLS_BR && br_taken) begin
                        ctrl_c[CTRL_PC_WRITE]          = 1'b1;
                        ctrl_c[CTRL_PC_SRC_LO +: 2]    = PC_SRC_BRANCH;
                    end
                end
                S_MEM: begin
                    ctrl_c[CTRL_IORD]                  = 1'b1;
                    ctrl_c[CTRL_MEM_READ]              = (cls == CLS_LWD);
                    ctrl_c[CTRL_MEM_WRITE]             = (cls == CLS_SWD);
                end
                S_WB: begin
                    ctrl_c[CTRL_REG_WRITE]             = 1'b1;
                    ctrl_c[CTRL_WB_SRC_LO +: 2]        = (cls == CLS_LWD) ? WB_SRC_MEM : WB_SRC_ALU;
                    ctrl_c[CTRL_DEST_LO +: 2]          = (cls == CLS_ALU) ? DEST_RD : DEST_RT;
                end
                default: ctrl_c = '0;
            endcase
        end
    end

    assign ctrl      = ctrl_c;
    assign state_o   = state_q;
    assign num_inst  = cnt_q;
    assign is_halted = halted_q;

endmodule

// File: tb/tb_mc_control_fsm.sv
// Bench for mc_control_fsm: instruction table plus hand-written halt, stall, wrap and reset sequences.
// A CNT_WIDTH=4 instance shares all inputs to observe counter wrap.
`timescale 1ns/1ps
module tb_mc_control_fsm;
    import mc_ctrl_pkg::*;

    logic                clk;
    logic                reset_n;
    logic                mem_ready;
    logic [15:0]         inst;
    logic [15:0]         bcond;
    logic [CTRL_NUM-1:0] ctrl, ctrl4;
    logic [2:0]          state_o, state4;
    logic [15:0]         num_inst;
    logic [3:0]          num_inst4;
    logic                is_halted, is_halted4;

    mc_control_fsm #(.WORD_SIZE(16), .CNT_WIDTH(16)) dut (
        .clk(clk), .reset_n(reset_n), .inst(inst), .bcond(bcond), .mem_ready(mem_ready),
        .ctrl(ctrl), .state_o(state_o), .num_inst(num_inst), .is_halted(is_halted)
    );

    mc_control_fsm #(.WORD_SIZE(16), .CNT_WIDTH(4)) dut4 (
        .clk(clk), .reset_n(reset_n), .inst(inst), .bcond(bcond), .mem_ready(mem_ready),
        .ctrl(ctrl4), .state_o(state4), .num_inst(num_inst4), .is_halted(is_halted4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0]          st;
        logic [CTRL_NUM-1:0] ct;
        logic                mr;
    } cyc_t;

    typedef struct {
        string       name;
        logic [15:0] inst;
        logic [15:0] bcond;
        int unsigned n;
        cyc_t [4:0]  cyc;
    } vec_t;

    cyc_t        expq[$];
    vec_t        tv[$];
    int unsigned n_pass  = 0;
    int unsigned n_total = 0;
    logic [15:0] exp_cnt;

    function automatic logic [CTRL_NUM-1:0] mk(input logic pcw, input logic irw, input logic mrd,
                                               input logic mwr, input logic iord, input logic rw,
                                               input logic oe, input logic [1:0] pcs,
                                               input logic [1:0] wbs, input logic [1:0] dst);
        logic [CTRL_NUM-1:0] c;
        c = '0;
        c[CTRL_PC_WRITE]  = pcw;
        c[CTRL_IR_WRITE]  = irw;
        c[CTRL_MEM_READ]  = mrd;
        c[CTRL_MEM_WRITE] = mwr;
        c[CTRL_IORD]      = iord;
        c[CTRL_REG_WRITE] = rw;
        c[CTRL_OUT_EN]    = oe;
        c[CTRL_PC_SRC_LO +: 2] = pcs;
        c[CTRL_WB_SRC_LO +: 2] = wbs;
        c[CTRL_DEST_LO +: 2]   = dst;
        return c;
    endfunction

    function automatic cyc_t cy(input logic [2:0] s, input logic [CTRL_NUM-1:0] c, input logic mr);
        cyc_t r;
        r.st = s; r.ct = c; r.mr = mr;
        return r;
    endfunction

    function automatic vec_t v(input string nm, input logic [15:0] i, input logic [15:0] b,
                               input int unsigned n, input cyc_t c0, input cyc_t c1,
                               input cyc_t c2, input cyc_t c3, input cyc_t c4);
        vec_t r;
        r.name = nm; r.inst = i; r.bcond = b; r.n = n;
        r.cyc[0] = c0; r.cyc[1] = c1; r.cyc[2] = c2; r.cyc[3] = c3; r.cyc[4] = c4;
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Drive one cycle: queue the expectation, compare at the falling edge, advance past the rising edge
    task automatic step(input string name, input cyc_t e);
        cyc_t g;
        mem_ready = e.mr;
        expq.push_back(e);
        @(negedge clk);
        g = expq.pop_front();
        check(name, {16'h0, state_o, ctrl}, {16'h0, g.st, g.ct});
        @(posedge clk);
        #1;
    endtask

    task automatic check_count(input string name);
        check({name, " num_inst"}, {16'h0, num_inst}, {16'h0, exp_cnt});
        check({name, " num_inst4"}, {28'h0, num_inst4}, {28'h0, exp_cnt[3:0]});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [CTRL_NUM-1:0] Z, CIF, CIF_WAIT, WB_R, WB_I, WB_L, MEM_L, MEM_S, EX_BR;
        logic [CTRL_NUM-1:0] ID_JMP, ID_JAL, ID_JPR, ID_JRL, ID_WWD;
        cyc_t pad;

        Z        = '0;
        CIF      = mk(1, 1, 1, 0, 0, 0, 0, PC_SRC_PC1, WB_SRC_ALU, DEST_RD);
        CIF_WAIT = mk(0, 0, 1, 0, 0, 0, 0, PC_SRC_PC1, WB_SRC_ALU, DEST_RD);
        WB_R     = mk(0, 0, 0, 0, 0, 1, 0, PC_SRC_PC1, WB_SRC_ALU, DEST_RD);
        WB_I     = mk(0, 0, 0, 0, 0, 1, 0, PC_SRC_PC1, WB_SRC_ALU, DEST_RT);
        WB_L     = mk(0, 0, 0, 0, 0, 1, 0, PC_SRC_PC1, WB_SRC_MEM, DEST_RT);
        MEM_L    = mk(0, 0, 1, 0, 1, 0, 0, PC_SRC_PC1, WB_SRC_ALU, DEST_RD);
        MEM_S    = mk(0, 0, 0, 1, 1, 0, 0, PC_SRC_PC1, WB_SRC_ALU, DEST_RD);
        EX_BR    = mk(1, 0, 0, 0, 0, 0, 0, PC_SRC_BRANCH, WB_SRC_ALU, DEST_RD);
        ID_JMP   = mk(1, 0, 0, 0, 0, 0, 0, PC_SRC_TARGET, WB_SRC_ALU, DEST_RD);
        ID_JAL   = mk(1, 0, 0, 0, 0, 1, 0, PC_SRC_TARGET, WB_SRC_PC, DEST_R2);
        ID_JPR   = mk(1, 0, 0, 0, 0, 0, 0, PC_SRC_REG, WB_SRC_ALU, DEST_RD);
        ID_JRL   = mk(1, 0, 0, 0, 0, 1, 0, PC_SRC_REG, WB_SRC_PC, DEST_R2);
        ID_WWD   = mk(0, 0, 0, 0, 0, 0, 1, PC_SRC_PC1, WB_SRC_ALU, DEST_RD);
        pad      = cy(3'd0, Z, 1'b1);

        tv.push_back(v("ADI", 16'h4123, 16'h0, 4, cy(S_IF, CIF, 1), cy(S_ID, Z, 1), cy(S_EX, Z, 1), cy(S_WB, WB_I, 1), pad));
        tv.push_back(v("ALU_ADD", 16'hF2C3, 16'h0, 4, cy(S_IF, CIF, 1), cy(S_ID, Z, 1), cy(S_EX, Z, 1), cy(S_WB, WB_R, 1), pad));
        tv.push_back(v("ORI", 16'h5A5A, 16'h0, 4, cy(S_IF, CIF, 1), cy(S_ID, Z, 1), cy(S_EX, Z, 1), cy(S_WB, WB_I, 1), pad));
        tv.push_back(v("LHI", 16'h6FFF, 16'h0, 4, cy(S_IF, CIF, 1), cy(S_ID, Z, 1), cy(S_EX, Z, 1), cy(S_WB, WB_I, 1), pad));
        tv.push_back(v("LWD", 16'h7044, 16'h0, 5, cy(S_IF, CIF, 1), cy(S_ID, Z, 1), cy(S_EX, Z, 1), cy(S_MEM, MEM_L, 1), cy(S_WB, WB_L, 1)));
        tv.push_back(v("SWD", 16'h8044, 16'h0, 4, cy(S_IF, CIF, 1), cy(S_ID, Z, 1), cy(S_EX, Z, 1), cy(S_MEM, MEM_S, 1), pad));
        tv.push_back(v("BEQ_T", 16'h1005, 16'h0000, 3, cy(S_IF, CIF, 1), cy(S_ID, Z, 1), cy(S_EX, EX_BR, 1), pad, pad));
        tv.push_back(v("BEQ_N", 16'h1005, 16'h0003, 3, cy(S_IF, CIF, 1), cy(S_ID, Z, 1), cy(S_EX, Z, 1), pad, pad));
        tv.push_back(v("BNE_T", 16'h0005, 16'h0003, 3, cy(S_IF, CIF, 1), cy(S_ID, Z, 1), cy(S_EX, EX_BR, 1), pad, pad));
        tv.push_back(v("BNE_N", 16'h0005, 16'h0000, 3, cy(S_IF, CIF, 1), cy(S_ID, Z, 1), cy(S_EX, Z, 1), pad, pad));
        tv.push_back(v("BGZ_T", 16'h2005, 16'h0001, 3, cy(S_IF, CIF, 1), cy(S_ID, Z, 1), cy(S_EX, EX_BR, 1), pad, pad));
        tv.push_back(v("BGZ_Z", 16'h2005, 16'h0000, 3, cy(S_IF, CIF, 1), cy(S_ID, Z, 1), cy(S_EX, Z, 1), pad, pad));
        tv.push_back(v("BGZ_NEG", 16'h2005, 16'hFFFF, 3, cy(S_IF, CIF, 1), cy(S_ID, Z, 1), cy(S_EX, Z, 1), pad, pad));
        tv.push_back(v("BLZ_T", 16'h3005, 16'h8000, 3, cy(S_IF, CIF, 1), cy(S_ID, Z, 1), cy(S_EX, EX_BR, 1), pad, pad));
        tv.push_back(v("BLZ_POS", 16'h3005, 16'h7FFF, 3, cy(S_IF, CIF, 1), cy(S_ID, Z, 1), cy(S_EX, Z, 1), pad, pad));
        tv.push_back(v("JMP", 16'h9123, 16'h0, 2, cy(S_IF, CIF, 1), cy(S_ID, ID_JMP, 1), pad, pad, pad));
        tv.push_back(v("JAL", 16'hA123, 16'h0, 2, cy(S_IF, CIF, 1), cy(S_ID, ID_JAL, 1), pad, pad, pad));
        tv.push_back(v("JPR", 16'hF019, 16'h0, 2, cy(S_IF, CIF, 1), cy(S_ID, ID_JPR, 1), pad, pad, pad));
        tv.push_back(v("JRL", 16'hF01A, 16'h0, 2, cy(S_IF, CIF, 1), cy(S_ID, ID_JRL, 1), pad, pad, pad));
        tv.push_back(v("WWD", 16'hF01C, 16'h0, 2, cy(S_IF, CIF, 1), cy(S_ID, ID_WWD, 1), pad, pad, pad));
        tv.push_back(v("NOP_OP11", 16'hB000, 16'h0, 2, cy(S_IF, CIF, 1), cy(S_ID, Z, 1), pad, pad, pad));
        tv.push_back(v("NOP_FN10", 16'hF00A, 16'h0, 2, cy(S_IF, CIF, 1), cy(S_ID, Z, 1), pad, pad, pad));
        tv.push_back(v("NOP_FN30", 16'hF01E, 16'h0, 2, cy(S_IF, CIF, 1), cy(S_ID, Z, 1), pad, pad, pad));

        // Reset state
        reset_n = 1'b0; mem_ready = 1'b1; inst = 16'h4123; bcond = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset state", {29'h0, state_o}, {29'h0, S_IF});
        check("reset ctrl", {19'h0, ctrl}, 32'h0);
        check("reset halted", {31'h0, is_halted}, 32'h0);
        exp_cnt = '0;
        check_count("reset");
        reset_n = 1'b1;

        for (int i = 0; i < tv.size(); i++) begin
            inst  = tv[i].inst;
            bcond = tv[i].bcond;
            for (int c = 0; c < int'(tv[i].n); c++) step(tv[i].name, tv[i].cyc[c]);
            exp_cnt++;
            check_count(tv[i].name);
        end

`ifdef MEM_HANDSHAKE_EN
        inst = 16'h7044; bcond = '0;
        step("LWD_HS", cy(S_IF, CIF, 1));
        step("LWD_HS", cy(S_ID, Z, 1));
        step("LWD_HS", cy(S_EX, Z, 1));
        for (int k = 0; k < 3; k++) step("LWD_HS mem wait", cy(S_MEM, MEM_L, 0));
        step("LWD_HS mem done", cy(S_MEM, MEM_L, 1));
        step("LWD_HS", cy(S_WB, WB_L, 1));
        exp_cnt++;
        check_count("LWD_HS");
        inst = 16'h4123;
        step("ADI_IFWAIT", cy(S_IF, CIF_WAIT, 0));
        step("ADI_IFWAIT", cy(S_IF, CIF, 1));
        step("ADI_IFWAIT", cy(S_ID, Z, 1));
        step("ADI_IFWAIT", cy(S_EX, Z, 1));
        step("ADI_IFWAIT", cy(S_WB, WB_I, 1));
        exp_cnt++;
        check_count("ADI_IFWAIT");
`else
        // mem_ready low must be ignored without the handshake
        inst = 16'h7044; bcond = '0;
        step("LWD_NOHS", cy(S_IF, CIF, 0));
        step("LWD_NOHS", cy(S_ID, Z, 0));
        step("LWD_NOHS", cy(S_EX, Z, 0));
        step("LWD_NOHS", cy(S_MEM, MEM_L, 0));
        step("LWD_NOHS", cy(S_WB, WB_L, 0));
        exp_cnt++;
        check_count("LWD_NOHS");
        if (CIF_WAIT == CIF) $display("FAIL CIF_WAIT: constant table broken");
`endif

        // HLT then idle cycles
        inst = 16'hF01D;
        check("pre-halt flag", {31'h0, is_halted}, 32'h0);
        step("HLT", cy(S_IF, CIF, 1));
        step("HLT", cy(S_ID, Z, 1));
        exp_cnt++;
        check_count("HLT");
        check("HLT halted", {31'h0, is_halted}, 32'h1);
        inst = 16'h4123;
        for (int k = 0; k < 10; k++) step("HALT idle", cy(S_HALT, Z, 1));
        check_count("HALT frozen");
        check("HALT sticky", {31'h0, is_halted}, 32'h1);

        reset_n = 1'b0;
        @(negedge clk);
        check("halt reset ctrl", {19'h0, ctrl}, 32'h0);
        @(posedge clk);
        #1;
        exp_cnt = '0;
        check("halt reset state", {29'h0, state_o}, {29'h0, S_IF});
        check("halt reset halted", {31'h0, is_halted}, 32'h0);
        check_count("halt reset");
        reset_n = 1'b1;

        // 16 NOP-class retirements wrap the 4-bit counter
        inst = 16'hB000;
        for (int k = 0; k < 16; k++) begin
            step("NOP wrap", cy(S_IF, CIF, 1));
            step("NOP wrap", cy(S_ID, Z, 1));
            exp_cnt++;
        end
        check("wrap num_inst4", {28'h0, num_inst4}, 32'h0);
        check("wrap num_inst", {16'h0, num_inst}, 32'd16);

        // Reset during EX of SWD aborts it
        inst = 16'h8044;
        step("SWD abort", cy(S_IF, CIF, 1));
        step("SWD abort", cy(S_ID, Z, 1));
        reset_n = 1'b0;
        @(negedge clk);
        check("SWD abort ctrl", {19'h0, ctrl}, 32'h0);
        check("SWD abort mem_write", {31'h0, ctrl[CTRL_MEM_WRITE]}, 32'h0);
        @(posedge clk);
        #1;
        exp_cnt = '0;
        check("SWD abort state", {29'h0, state_o}, {29'h0, S_IF});
        check_count("SWD abort");
        reset_n = 1'b1;

        inst = 16'h4123;
        step("ADI after reset", cy(S_IF, CIF, 1));
        step("ADI after reset", cy(S_ID, Z, 1));
        step("ADI after reset", cy(S_EX, Z, 1));
        step("ADI after reset", cy(S_WB, WB_I, 1));
        exp_cnt++;
        check_count("ADI after reset");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
